// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: shadowed sprite registers, hblank scan,
// priority-ordered visible-sprite list for the pixel datapath.
// Ports: clk, reset_n, Avalon slave (chipselect/write/address/writedata),
// vcount/line_start/frame_start timing; act_* list, act_count, list_valid,
// overflow, busy.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_H     = 32,
  parameter int V_TOTAL      = 525
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic [8:0]                address,
  input  logic [31:0]               writedata,
  input  logic [9:0]                vcount,
  input  logic                      line_start,
  input  logic                      frame_start,
  output logic [MAX_PER_LINE*3-1:0] act_id,
  output logic [MAX_PER_LINE*11-1:0] act_x,
  output logic [MAX_PER_LINE*5-1:0] act_row,
  output logic [2:0]                act_count,
  output logic                      list_valid,
  output logic                      overflow,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int RW = $clog2(SPRITE_H);

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  state_t state_q, state_d;

  logic [10:0] p_x [NUM_SPRITES];
  logic [9:0]  p_y [NUM_SPRITES];
  logic        p_en [NUM_SPRITES];
  logic [10:0] l_x [NUM_SPRITES];
  logic [9:0]  l_y [NUM_SPRITES];
  logic        l_en [NUM_SPRITES];

  logic [9:0]  tl;
  logic [IW-1:0] idx;
  logic [MAX_PER_LINE*3-1:0]  b_id, o_id;
  logic [MAX_PER_LINE*11-1:0] b_x, o_x;
  logic [MAX_PER_LINE*5-1:0]  b_row, o_row;
  logic [2:0]  b_cnt, o_cnt;
  logic        b_ovf, o_ovf;

  logic          wr_ok;
  logic [IW-1:0] wslot;
  logic          last;
  logic          hit;
  logic [10:0]   tl11, y11, diff;
  logic          publish;

  assign wr_ok = chipselect && write &&
                 (address < 9'(2 * NUM_SPRITES));
  assign wslot = address[IW:1];

  // Pending bank takes writes; live bank copies it on frame_start.
  // Nonblocking copy means a same-cycle write misses this frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        p_x[i]  <= '0;
        p_y[i]  <= '0;
        p_en[i] <= 1'b0;
        l_x[i]  <= '0;
        l_y[i]  <= '0;
        l_en[i] <= 1'b0;
      end
    end else begin
      if (wr_ok) begin
        if (address[0]) begin
          p_en[wslot] <= writedata[16];
          p_y[wslot]  <= writedata[9:0];
        end else begin
          p_x[wslot] <= writedata[10:0];
        end
      end
      if (frame_start) begin
        l_x  <= p_x;
        l_y  <= p_y;
        l_en <= p_en;
      end
    end
  end

  assign last = (idx == IW'(NUM_SPRITES - 1));
  assign tl11 = {1'b0, tl};
  assign y11  = {1'b0, l_y[idx]};
  assign diff = tl11 - y11;
  assign hit  = l_en[idx] && (tl11 >= y11) &&
                (tl11 < y11 + 11'(SPRITE_H));

  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = SCAN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        SCAN:    state_d = last ? PUBLISH : SCAN;
        PUBLISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tl    <= '0;
      idx   <= '0;
      b_id  <= '0;
      b_x   <= '0;
      b_row <= '0;
      b_cnt <= '0;
      b_ovf <= 1'b0;
    end else if (line_start) begin
      tl    <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      idx   <= '0;
      b_id  <= '0;
      b_x   <= '0;
      b_row <= '0;
      b_cnt <= '0;
      b_ovf <= 1'b0;
    end else if (state_q == SCAN) begin
      idx <= idx + 1'b1;
      if (hit) begin
        if (b_cnt < 3'(MAX_PER_LINE)) begin
          b_id[int'(b_cnt)*3 +: 3]   <= 3'(idx);
          b_x[int'(b_cnt)*11 +: 11]  <= l_x[idx];
          b_row[int'(b_cnt)*5 +: 5]  <= 5'(diff[RW-1:0]);
          b_cnt <= b_cnt + 3'd1;
        end else begin
          b_ovf <= 1'b1;
        end
      end
    end
  end

  // A line_start landing on the publish cycle cancels that publish.
  assign publish = (state_q == PUBLISH) && !line_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_id  <= '0;
      o_x   <= '0;
      o_row <= '0;
      o_cnt <= '0;
      o_ovf <= 1'b0;
    end else if (publish) begin
      o_id  <= b_id;
      o_x   <= b_x;
      o_row <= b_row;
      o_cnt <= b_cnt;
      o_ovf <= b_ovf;
    end
  end

  assign act_id     = publish ? b_id  : o_id;
  assign act_x      = publish ? b_x   : o_x;
  assign act_row    = publish ? b_row : o_row;
  assign act_count  = publish ? b_cnt : o_cnt;
  assign overflow   = publish ? b_ovf : o_ovf;
  assign list_valid = publish;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed self-checking bench for sprite_line_scheduler.
// Tasks per scenario; expected values hand-computed.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [8:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [9:0]  vcount = '0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] act_id;
  logic [43:0] act_x;
  logic [19:0] act_row;
  logic [2:0]  act_count;
  logic        list_valid;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] EN = 32'h1_0000;

  sprite_line_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata),
    .vcount(vcount), .line_start(line_start),
    .frame_start(frame_start),
    .act_id(act_id), .act_x(act_x), .act_row(act_row),
    .act_count(act_count), .list_valid(list_valid),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Returns the cycle (relative to line_start) of list_valid, 0 on timeout.
  task automatic run_line(input logic [9:0] v, output int lat,
                          output logic bsy1);
    lat = 0;
    bsy1 = 1'b0;
    @(negedge clk);
    line_start = 1'b1; vcount = v;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        line_start = 1'b0;
        bsy1 = busy;
      end
      if (list_valid) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat == 0) begin
      n_bad++;
      $display("FAIL list_valid_timeout line %0d: no pulse in 20 cycles", v);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({act_count, list_valid, overflow, busy} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 0",
               {act_count, list_valid, overflow, busy});
    end
    n_cmp++;
    if ({act_id, act_x, act_row} !== 76'd0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", {act_id, act_x, act_row});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic b1;
    wr(9'd0, 32'd40);
    wr(9'd1, EN | 32'd100);
    frame();
    run_line(10'd99, lat, b1);
    n_cmp++;
    if (lat !== 9) begin
      n_bad++; $display("FAIL basic_latency got %0d want 9", lat);
    end
    n_cmp++;
    if (b1 !== 1'b1) begin
      n_bad++; $display("FAIL basic_busy got %b want 1", b1);
    end
    n_cmp++;
    if (act_count !== 3'd1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_count got %0d/%b want 1/0", act_count, overflow);
    end
    n_cmp++;
    if (act_id[2:0] !== 3'd0 || act_x[10:0] !== 11'd40 ||
        act_row[4:0] !== 5'd0) begin
      n_bad++;
      $display("FAIL basic_entry0 got id%0d x%0d row%0d want 0 40 0",
               act_id[2:0], act_x[10:0], act_row[4:0]);
    end
    n_cmp++;
    if (act_x[43:11] !== 33'd0) begin
      n_bad++; $display("FAIL basic_unused got %h want 0", act_x[43:11]);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || list_valid !== 1'b0 || act_count !== 3'd1) begin
      n_bad++;
      $display("FAIL basic_after got busy%b lv%b cnt%0d want 0 0 1",
               busy, list_valid, act_count);
    end
  endtask

  task automatic test_rows();
    int lat;
    logic b1;
    run_line(10'd130, lat, b1);
    n_cmp++;
    if (act_count !== 3'd1 || act_row[4:0] !== 5'd31) begin
      n_bad++;
      $display("FAIL rows_last got cnt%0d row%0d want 1 31",
               act_count, act_row[4:0]);
    end
    run_line(10'd131, lat, b1);
    n_cmp++;
    if (act_count !== 3'd0 || act_row !== 20'd0) begin
      n_bad++;
      $display("FAIL rows_below got cnt%0d want 0", act_count);
    end
    run_line(10'd98, lat, b1);
    n_cmp++;
    if (act_count !== 3'd0) begin
      n_bad++; $display("FAIL rows_above got %0d want 0", act_count);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic b1;
    for (int i = 1; i < 8; i++) begin
      if (i != 3) begin
        wr(9'(2 * i), 32'(10 * i));
        wr(9'(2 * i + 1), EN | 32'd200);
      end
    end
    wr(9'd16, 32'd7);
    wr(9'd17, EN | 32'd200);
    frame();
    run_line(10'd199, lat, b1);
    n_cmp++;
    if (act_count !== 3'd4 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_count got %0d/%b want 4/1", act_count, overflow);
    end
    n_cmp++;
    if (act_id !== {3'd5, 3'd4, 3'd2, 3'd1}) begin
      n_bad++; $display("FAIL ovf_ids got %h want %h", act_id,
                        {3'd5, 3'd4, 3'd2, 3'd1});
    end
    n_cmp++;
    if (act_x !== {11'd50, 11'd40, 11'd20, 11'd10} || act_row !== 20'd0) begin
      n_bad++; $display("FAIL ovf_x got %h want %h", act_x,
                        {11'd50, 11'd40, 11'd20, 11'd10});
    end
  endtask

  task automatic test_shadow();
    int lat;
    logic b1;
    wr(9'd1, EN | 32'd150);
    run_line(10'd99, lat, b1);
    n_cmp++;
    if (act_count !== 3'd1 || act_row[4:0] !== 5'd0) begin
      n_bad++;
      $display("FAIL shadow_hold got cnt%0d row%0d want 1 0",
               act_count, act_row[4:0]);
    end
    frame();
    run_line(10'd149, lat, b1);
    n_cmp++;
    if (act_count !== 3'd1 || act_x[10:0] !== 11'd40) begin
      n_bad++;
      $display("FAIL shadow_new got cnt%0d x%0d want 1 40",
               act_count, act_x[10:0]);
    end
    run_line(10'd99, lat, b1);
    n_cmp++;
    if (act_count !== 3'd0) begin
      n_bad++; $display("FAIL shadow_old_gone got %0d want 0", act_count);
    end
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 9'd1;
    writedata = EN | 32'd300; frame_start = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; frame_start = 1'b0;
    run_line(10'd149, lat, b1);
    n_cmp++;
    if (act_count !== 3'd1 || act_row[4:0] !== 5'd0) begin
      n_bad++;
      $display("FAIL shadow_same_cycle got cnt%0d want 1", act_count);
    end
    frame();
    run_line(10'd299, lat, b1);
    n_cmp++;
    if (act_count !== 3'd1 || act_id[2:0] !== 3'd0) begin
      n_bad++;
      $display("FAIL shadow_next_frame got cnt%0d want 1", act_count);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic b1;
    int pulses;
    int first;
    logic [4:0] row;
    wr(9'd6, 32'd77);
    wr(9'd7, EN | 32'd0);
    frame();
    run_line(10'd524, lat, b1);
    n_cmp++;
    if (act_count !== 3'd1 || act_id[2:0] !== 3'd3 ||
        act_x[10:0] !== 11'd77 || act_row[4:0] !== 5'd0) begin
      n_bad++;
      $display("FAIL wrap got cnt%0d id%0d x%0d row%0d want 1 3 77 0",
               act_count, act_id[2:0], act_x[10:0], act_row[4:0]);
    end
    pulses = 0; first = 0; row = '0;
    @(negedge clk);
    line_start = 1'b1; vcount = 10'd524;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    line_start = 1'b1; vcount = 10'd10;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) line_start = 1'b0;
      if (list_valid) begin
        pulses++;
        if (first == 0) begin
          first = k;
          row = act_row[4:0];
        end
      end
    end
    n_cmp++;
    if (pulses !== 1 || first !== 9) begin
      n_bad++;
      $display("FAIL restart_pulses got %0d@%0d want 1@9", pulses, first);
    end
    n_cmp++;
    if (row !== 5'd11 || act_count !== 3'd1) begin
      n_bad++;
      $display("FAIL restart_row got row%0d cnt%0d want 11 1",
               row, act_count);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic b1;
    @(negedge clk);
    line_start = 1'b1; vcount = 10'd524;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({act_count, busy, overflow} !== 5'd0 ||
        {act_id, act_x, act_row} !== 76'd0) begin
      n_bad++;
      $display("FAIL async_reset got cnt%0d busy%b x%h want 0",
               act_count, busy, act_x);
    end
    @(negedge clk);
    reset_n = 1'b1;
    frame();
    run_line(10'd10, lat, b1);
    n_cmp++;
    if (act_count !== 3'd0 || lat !== 9) begin
      n_bad++;
      $display("FAIL post_reset got cnt%0d lat%0d want 0 9", act_count, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rows();
    test_overflow();
    test_shadow();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
